// File: rtl/piece_move_sched.sv
// piece_move_sched: turns gravity ticks and sampled player inputs into a
// single stream of board operations, and sequences the piece lifecycle
// (clear, spawn, fall, lock, respawn) including game-over detection.
// Only one board operation is ever outstanding.
module piece_move_sched #(
    parameter int LOCK_DELAY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vertical_flag,
    input  logic       horizontal_flag,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rot,
    input  logic       btn_drop,
    input  logic       start,
    output logic       req_valid,
    output logic [2:0] req_op,
    input  logic       req_ready,
    input  logic       rsp_valid,
    input  logic       rsp_blocked,
    output logic       lock_pulse,
    output logic       game_over
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_SPAWN = 3'd2;
    localparam logic [2:0] ST_PLAY  = 3'd3;
    localparam logic [2:0] ST_ISSUE = 3'd4;
    localparam logic [2:0] ST_WAIT  = 3'd5;
    localparam logic [2:0] ST_LOCK  = 3'd6;
    localparam logic [2:0] ST_OVER  = 3'd7;

    localparam logic [2:0] OP_SPAWN = 3'd0;
    localparam logic [2:0] OP_LEFT  = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_ROT   = 3'd3;
    localparam logic [2:0] OP_DOWN  = 3'd4;
    localparam logic [2:0] OP_LOCK  = 3'd5;
    localparam logic [2:0] OP_CLEAR = 3'd6;

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_DELAY);

    logic [2:0] state_q, state_d;
    logic       req_valid_q, req_valid_d;
    logic [2:0] req_op_q, req_op_d;
    logic       sent_q, sent_d;
    logic [3:0] lock_cnt_q, lock_cnt_d;
    logic       lock_pulse_q, lock_pulse_d;
    logic       game_over_q, game_over_d;
    logic       g_pend_q, g_pend_d;
    logic       rot_pend_q, rot_pend_d;
    logic       l_pend_q, l_pend_d;
    logic       r_pend_q, r_pend_d;

    logic [3:0] lock_cnt_inc;
    logic [2:0] fixed_op;
    logic       any_pend;

    assign req_valid  = req_valid_q;
    assign req_op     = req_op_q;
    assign lock_pulse = lock_pulse_q;
    assign game_over  = game_over_q;

    // Lifecycle FSM: fixed-op states (CLEAR/SPAWN/LOCK) raise a request, wait
    // for the transfer, then wait for the response; PLAY arbitrates pending
    // moves and ISSUE/WAIT carry one move through the datapath.
    always_comb begin
        state_d      = state_q;
        req_valid_d  = req_valid_q;
        req_op_d     = req_op_q;
        sent_d       = sent_q;
        lock_cnt_d   = lock_cnt_q;
        lock_pulse_d = 1'b0;
        game_over_d  = game_over_q;
        lock_cnt_inc = (lock_cnt_q == 4'hF) ? 4'hF : lock_cnt_q + 4'd1;
        any_pend     = g_pend_q | rot_pend_q | l_pend_q | r_pend_q;
        case (state_q)
            ST_CLEAR: fixed_op = OP_CLEAR;
            ST_SPAWN: fixed_op = OP_SPAWN;
            default:  fixed_op = OP_LOCK;
        endcase

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d     = ST_CLEAR;
                    sent_d      = 1'b0;
                    req_valid_d = 1'b0;
                end
            end
            ST_CLEAR, ST_SPAWN, ST_LOCK: begin
                if (!sent_q) begin
                    if (!req_valid_q) begin
                        req_valid_d = 1'b1;
                        req_op_d    = fixed_op;
                    end else if (req_ready) begin
                        req_valid_d = 1'b0;
                        sent_d      = 1'b1;
                    end
                end else if (rsp_valid) begin
                    sent_d = 1'b0;
                    if (state_q == ST_CLEAR) begin
                        state_d = ST_SPAWN;
                    end else if (state_q == ST_LOCK) begin
                        lock_pulse_d = 1'b1;
                        state_d      = ST_SPAWN;
                    end else if (rsp_blocked) begin
                        game_over_d = 1'b1;
                        state_d     = ST_OVER;
                    end else begin
                        game_over_d = 1'b0;
                        lock_cnt_d  = 4'd0;
                        state_d     = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                if (any_pend) begin
                    req_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                    if (g_pend_q) begin
                        req_op_d = OP_DOWN;
                    end else if (rot_pend_q) begin
                        req_op_d = OP_ROT;
                    end else if (l_pend_q) begin
                        req_op_d = OP_LEFT;
                    end else begin
                        req_op_d = OP_RIGHT;
                    end
                end
            end
            ST_ISSUE: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_valid) begin
                    state_d = ST_PLAY;
                    if (req_op_q == OP_DOWN) begin
                        if (rsp_blocked) begin
                            lock_cnt_d = lock_cnt_inc;
                            if (lock_cnt_inc == LOCK_LIM) begin
                                state_d = ST_LOCK;
                            end
                        end else begin
                            lock_cnt_d = 4'd0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending move bits: set by ticks (set wins over the transfer clear),
    // cleared when their move transfers, flushed entering SPAWN and held
    // clear while idle or game over.
    always_comb begin
        logic flush;
        logic xfer;
        flush = (state_d == ST_IDLE) || (state_d == ST_OVER) ||
                ((state_d == ST_SPAWN) && (state_q != ST_SPAWN));
        xfer  = (state_q == ST_ISSUE) && req_ready;
        g_pend_d   = vertical_flag | (horizontal_flag & btn_drop) |
                     (g_pend_q & ~(xfer && (req_op_q == OP_DOWN)));
        rot_pend_d = (horizontal_flag & btn_rot) |
                     (rot_pend_q & ~(xfer && (req_op_q == OP_ROT)));
        l_pend_d   = (horizontal_flag & btn_left & ~btn_right) |
                     (l_pend_q & ~(xfer && (req_op_q == OP_LEFT)));
        r_pend_d   = (horizontal_flag & btn_right & ~btn_left) |
                     (r_pend_q & ~(xfer && (req_op_q == OP_RIGHT)));
        if (flush) begin
            g_pend_d   = 1'b0;
            rot_pend_d = 1'b0;
            l_pend_d   = 1'b0;
            r_pend_d   = 1'b0;
        end
    end

    // State and output registers, asynchronously cleared by active-low rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            req_valid_q  <= 1'b0;
            req_op_q     <= 3'd0;
            sent_q       <= 1'b0;
            lock_cnt_q   <= 4'd0;
            lock_pulse_q <= 1'b0;
            game_over_q  <= 1'b0;
            g_pend_q     <= 1'b0;
            rot_pend_q   <= 1'b0;
            l_pend_q     <= 1'b0;
            r_pend_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            req_op_q     <= req_op_d;
            sent_q       <= sent_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_pulse_q <= lock_pulse_d;
            game_over_q  <= game_over_d;
            g_pend_q     <= g_pend_d;
            rot_pend_q   <= rot_pend_d;
            l_pend_q     <= l_pend_d;
            r_pend_q     <= r_pend_d;
        end
    end

endmodule

// File: tb/tb_piece_move_sched.sv
// Testbench for piece_move_sched: a randomized datapath responder plus a
// transaction-level model that predicts the sequence of board operations.
module tb_piece_move_sched;

    localparam int LOCK_DELAY = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       vertical_flag, horizontal_flag;
    logic       btn_left, btn_right, btn_rot, btn_drop, start;
    logic       req_valid;
    logic [2:0] req_op;
    logic       req_ready, rsp_valid, rsp_blocked;
    logic       lock_pulse, game_over;

    int   totalChecks = 0;
    int   badChecks = 0;
    int   obsOps[$];
    int   expOps[$];
    bit   downBlk[$];
    bit   spawnBlk = 1'b0;
    bit   rspPending = 1'b0;
    int   rspCnt = 0;
    int   rspOp = 0;
    bit   holdReady = 1'b0;
    bit   expGo = 1'b0;
    bit   expLp = 1'b0;
    int   lockPulses = 0;
    int   lockExp = 0;
    int   lockCnt = 0;
    bit   overModel = 1'b0;
    bit   prevValid = 1'b0;
    bit   prevXfer = 1'b0;
    int   prevOp = 0;
    bit   tbRun = 1'b0;

    always #5 clk = ~clk;

    piece_move_sched #(.LOCK_DELAY(LOCK_DELAY)) dut (
        .clk(clk),
        .rst(rst),
        .vertical_flag(vertical_flag),
        .horizontal_flag(horizontal_flag),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_rot(btn_rot),
        .btn_drop(btn_drop),
        .start(start),
        .req_valid(req_valid),
        .req_op(req_op),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_blocked(rsp_blocked),
        .lock_pulse(lock_pulse),
        .game_over(game_over)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalChecks++;
        if (observed != expected) begin
            badChecks++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Datapath stand-in: random ready, responses 1..3 cycles after transfer,
    // and per-cycle checks of handshake rules, lock_pulse and game_over.
    initial begin
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_blocked = 1'b0;
        wait (tbRun);
        forever begin
            @(negedge clk);
            checkOutput("lock_pulse", int'(lock_pulse), int'(expLp));
            if (lock_pulse) lockPulses++;
            expLp = 1'b0;
            checkOutput("game_over", int'(game_over), int'(expGo));
            if (prevValid && !prevXfer) begin
                checkOutput("valid_hold", int'(req_valid), 1);
                if (req_valid) checkOutput("op_stable", int'(req_op), prevOp);
            end
            if (req_valid) checkOutput("one_outstanding", int'(rspPending), 0);
            rsp_valid   = 1'b0;
            rsp_blocked = 1'b0;
            if (rspPending) begin
                if (rspCnt == 0) begin
                    rsp_valid  = 1'b1;
                    rspPending = 1'b0;
                    case (rspOp)
                        4: rsp_blocked = (downBlk.size() > 0) ? downBlk.pop_front() : 1'b0;
                        0: begin
                            rsp_blocked = spawnBlk;
                            expGo       = spawnBlk;
                        end
                        5: begin
                            rsp_blocked = 1'b0;
                            expLp       = 1'b1;
                        end
                        default: rsp_blocked = 1'($urandom_range(0, 1));
                    endcase
                end else begin
                    rspCnt--;
                end
            end
            req_ready = holdReady ? 1'b0 : ($urandom_range(0, 9) < 7);
            prevValid = req_valid;
            prevOp    = int'(req_op);
            prevXfer  = req_valid && req_ready;
            if (req_valid && req_ready) begin
                obsOps.push_back(int'(req_op));
                rspPending = 1'b1;
                rspOp      = int'(req_op);
                rspCnt     = int'($urandom_range(0, 2));
            end
        end
    end

    // One-cycle pulse of ticks, buttons and start, then everything released.
    task automatic applyStimulus(input bit v, input bit h, input bit bl, input bit br,
                                 input bit brot, input bit bdrop, input bit st);
        @(negedge clk);
        vertical_flag   = v;
        horizontal_flag = h;
        btn_left        = bl;
        btn_right       = br;
        btn_rot         = brot;
        btn_drop        = bdrop;
        start           = st;
        @(negedge clk);
        vertical_flag   = 1'b0;
        horizontal_flag = 1'b0;
        btn_left        = 1'b0;
        btn_right       = 1'b0;
        btn_rot         = 1'b0;
        btn_drop        = 1'b0;
        start           = 1'b0;
    endtask

    // Waits for the expected operations to drain, then compares the sequence.
    task automatic waitOps();
        int c;
        c = 0;
        while (c < 500 && !(obsOps.size() >= expOps.size() && !rspPending)) begin
            @(negedge clk);
            c++;
        end
        repeat (20) @(negedge clk);
        checkOutput("drain_in_time", int'(c < 500), 1);
        checkOutput("op_count", obsOps.size(), expOps.size());
        foreach (expOps[i]) begin
            checkOutput("op_seq", (i < obsOps.size()) ? obsOps[i] : -1, expOps[i]);
        end
        obsOps.delete();
        expOps.delete();
    endtask

    // Predicts the operations produced by one burst of inputs from an idle
    // PLAY state: priority DOWN > ROT > LEFT > RIGHT, lock after LOCK_DELAY
    // consecutive blocked DOWNs, and a lock discards the remaining moves.
    task automatic runScenario(input bit v, input bit h, input bit bl, input bit br,
                               input bit brot, input bit bdrop, input bit blk, input bit st);
        bit g, rot, l, r, locked;
        g      = v | (h & bdrop);
        rot    = h & brot;
        l      = h & bl & ~br;
        r      = h & br & ~bl;
        locked = 1'b0;
        if (!overModel) begin
            if (g) begin
                expOps.push_back(4);
                downBlk.push_back(blk);
                if (blk) begin
                    lockCnt = (lockCnt >= 15) ? 15 : lockCnt + 1;
                    if (lockCnt == LOCK_DELAY) begin
                        expOps.push_back(5);
                        expOps.push_back(0);
                        lockExp++;
                        locked = 1'b1;
                        if (spawnBlk) overModel = 1'b1;
                        else lockCnt = 0;
                    end
                end else begin
                    lockCnt = 0;
                end
            end
            if (!locked) begin
                if (rot) expOps.push_back(3);
                if (l) expOps.push_back(1);
                if (r) expOps.push_back(2);
            end
        end
        applyStimulus(v, h, bl, br, brot, bdrop, st);
        waitOps();
    endtask

    initial begin
        rst             = 1'b0;
        vertical_flag   = 1'b0;
        horizontal_flag = 1'b0;
        btn_left        = 1'b0;
        btn_right       = 1'b0;
        btn_rot         = 1'b0;
        btn_drop        = 1'b0;
        start           = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_req_valid", int'(req_valid), 0);
        checkOutput("rst_req_op", int'(req_op), 0);
        checkOutput("rst_lock_pulse", int'(lock_pulse), 0);
        checkOutput("rst_game_over", int'(game_over), 0);
        rst   = 1'b1;
        tbRun = 1'b1;
        @(negedge clk);

        $display("[TB] start: expect CLEAR then SPAWN");
        expOps.push_back(6);
        expOps.push_back(0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        waitOps();
        checkOutput("go_after_start", int'(game_over), 0);

        $display("[TB] priority, conflict, ignored start");
        runScenario(1, 1, 1, 0, 1, 0, 0, 0);
        runScenario(0, 1, 1, 1, 0, 0, 0, 0);
        runScenario(0, 0, 0, 0, 0, 0, 0, 1);

        $display("[TB] lock delay and counter reset");
        runScenario(1, 0, 0, 0, 0, 0, 1, 0);
        runScenario(1, 0, 0, 0, 0, 0, 1, 0);
        runScenario(1, 0, 0, 0, 0, 0, 1, 0);
        runScenario(1, 0, 0, 0, 0, 0, 0, 0);
        runScenario(1, 0, 0, 0, 0, 0, 1, 0);
        runScenario(0, 1, 0, 0, 0, 1, 0, 0);

        $display("[TB] backpressure");
        holdReady = 1'b1;
        @(negedge clk);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("bp_valid", int'(req_valid), 1);
        checkOutput("bp_op", int'(req_op), 4);
        for (int k = 0; k < 4; k++) begin
            repeat (3) @(negedge clk);
            applyStimulus(1, 0, 0, 0, 0, 0, 0);
        end
        checkOutput("bp_valid_end", int'(req_valid), 1);
        checkOutput("bp_op_end", int'(req_op), 4);
        downBlk.push_back(1'b0);
        lockCnt = 0;
        expOps.push_back(4);
        holdReady = 1'b0;
        waitOps();
        runScenario(1, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] randomized bursts");
        for (int n = 0; n < 30; n++) begin
            runScenario(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] game over and restart");
        spawnBlk = 1'b1;
        for (int k = 0; k < LOCK_DELAY + 1 && !overModel; k++) begin
            runScenario(1, 0, 0, 0, 0, 0, 1, 0);
        end
        checkOutput("go_level", int'(game_over), 1);
        runScenario(1, 1, 1, 0, 1, 1, 0, 0);
        checkOutput("go_hold", int'(game_over), 1);
        spawnBlk = 1'b0;
        expOps.push_back(6);
        expOps.push_back(0);
        overModel = 1'b0;
        lockCnt   = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        waitOps();
        checkOutput("go_clear", int'(game_over), 0);
        runScenario(1, 1, 0, 1, 0, 0, 0, 0);

        checkOutput("lock_pulse_count", lockPulses, lockExp);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
